// File: rtl/lfsr_rng_arbiter_if.sv
// Request/grant bus between the shared random source and its consumers.
// The consumer side drives req; the arbiter side returns gnt and rand_out.
interface lfsr_rng_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int OUT_W = 16
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [OUT_W-1:0] rand_out;

  modport master (output req, input gnt, input rand_out);
  modport slave  (input req, output gnt, output rand_out);
endinterface

// File: rtl/lfsr_rng_arbiter.sv
// Shared 64-bit XNOR Fibonacci LFSR, handed out round-robin to N_REQ requesters.
// Each grant advances the LFSR by SHIFTS fresh steps before the word is returned.
module lfsr_rng_arbiter #(
  parameter int          N_REQ        = 4,
  parameter int          OUT_W        = 16,
  parameter int          SHIFTS       = 16,
  parameter logic [63:0] DEFAULT_SEED = 64'h1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                seed_load,
  input  logic [63:0]         seed_in,
  input  logic                free_run,
  output logic                busy,
  lfsr_rng_arbiter_if.slave   bus
);

  localparam int               PTR_W     = $clog2(N_REQ);
  localparam logic [63:0]      ALL_ONES  = '1;
  localparam logic [63:0]      SAFE_SEED = (DEFAULT_SEED == ALL_ONES) ? 64'h1 : DEFAULT_SEED;
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(N_REQ - 1);
  localparam logic [7:0]       LAST_CNT  = 8'(SHIFTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GRANT
  } fsm_t;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  // All-ones is a fixed point of the XNOR step, so it must never be stored.
  function automatic logic [63:0] sanitize(input logic [63:0] s);
    return (s == ALL_ONES) ? SAFE_SEED : s;
  endfunction

  fsm_t             r_fsm,    w_fsm_nxt;
  logic [63:0]      r_state,  w_state_nxt;
  logic [7:0]       r_cnt,    w_cnt_nxt;
  logic [PTR_W-1:0] r_owner,  w_owner_nxt;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_nxt;

  logic             w_pick_vld;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W-1:0] w_scan;
  logic [PTR_W-1:0] w_owner_inc;
  logic             w_grant_fire;

  // Scan from the farthest offset down so the nearest asserted req after rr_ptr wins.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_scan     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_scan = PTR_W'((int'(r_rr_ptr) + i) % N_REQ);
      if (bus.req[w_scan]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_scan;
      end
    end
  end

  assign w_owner_inc = (r_owner == LAST_PTR) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;

    if (seed_load) begin
      // A seed load cancels any in-flight grant and leaves rr_ptr alone.
      w_state_nxt = sanitize(seed_in);
      w_fsm_nxt   = S_IDLE;
    end else begin
      unique case (r_fsm)
        S_IDLE: begin
          if (w_pick_vld) begin
            w_owner_nxt = w_pick;
            w_cnt_nxt   = '0;
            w_fsm_nxt   = S_SHIFT;
          end else if (free_run) begin
            w_state_nxt = lfsr_step(r_state);
          end
        end
        S_SHIFT: begin
          w_state_nxt = lfsr_step(r_state);
          w_cnt_nxt   = r_cnt + 8'd1;
          if (r_cnt == LAST_CNT) w_fsm_nxt = S_GRANT;
        end
        S_GRANT: begin
          w_rr_nxt  = w_owner_inc;
          w_fsm_nxt = S_IDLE;
        end
        default: w_fsm_nxt = S_IDLE;
      endcase
    end
  end

  // The word is only handed out if the owner is still asking for it.
  assign w_grant_fire = (r_fsm == S_GRANT) && bus.req[r_owner] && !seed_load && !reset;

  always_comb begin
    busy         = (r_fsm != S_IDLE);
    bus.gnt      = w_grant_fire ? (ONE_HOT0 << r_owner) : '0;
    bus.rand_out = w_grant_fire ? r_state[OUT_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      r_fsm    <= S_IDLE;
      r_state  <= SAFE_SEED;
      r_cnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_fsm    <= w_fsm_nxt;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter: seeding, latency, round-robin order,
// cancellation by seed_load, dropped requests, reset in GRANT and free-run stepping.
module tb_lfsr_rng_arbiter;

  localparam int N_REQ  = 4;
  localparam int OUT_W  = 16;
  localparam int SHIFTS = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [63:0] seed_in;
  logic        free_run;
  logic        busy;

  lfsr_rng_arbiter_if #(.N_REQ(N_REQ), .OUT_W(OUT_W)) bus ();

  lfsr_rng_arbiter #(
    .N_REQ        (N_REQ),
    .OUT_W        (OUT_W),
    .SHIFTS       (SHIFTS),
    .DEFAULT_SEED (64'h1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .free_run  (free_run),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.gnt == '0 && n < 40);
  endtask

  function automatic logic [63:0] lfsr_steps(input logic [63:0] s, input int n);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[62:0], ~(v[63] ^ v[62] ^ v[60] ^ v[59])};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [63:0] m_state;
    logic [63:0] seed_v;
    logic [3:0]  exp_g;

    reset     = 1'b1;
    seed_load = 1'b0;
    seed_in   = '0;
    free_run  = 1'b0;
    bus.req   = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_gnt",   bus.gnt,      '0);
    check("rst_rand",  bus.rand_out, '0);
    check("rst_busy",  busy,         '0);
    check("rst_state", dut.r_state,  64'h1);
    check("rst_rr",    dut.r_rr_ptr, '0);

    // Zero seed: sixteen XNOR steps shift in sixteen ones
    seed_load = 1'b1; seed_in = '0;
    tick();
    seed_load = 1'b0;
    check("seed_zero", dut.r_state, 64'h0);

    bus.req = 4'b0001;
    wait_gnt(n);
    check("lat_first",   n,            17);
    check("gnt_first",   bus.gnt,      4'b0001);
    check("rand_first",  bus.rand_out, 16'hFFFF);
    check("state_first", dut.r_state,  64'h0000_0000_0000_FFFF);
    check("busy_grant",  busy,         1'b1);
    bus.req = '0;
    tick();
    check("gap_busy", busy,         1'b0);
    check("gap_gnt",  bus.gnt,      '0);
    check("gap_rr",   dut.r_rr_ptr, 1);

    bus.req = 4'b0001;
    wait_gnt(n);
    check("lat_second",   n,            17);
    check("rand_second",  bus.rand_out, 16'hFFFF);
    check("state_second", dut.r_state,  64'h0000_0000_FFFF_FFFF);
    bus.req = '0;
    tick();

    // All-ones seed is replaced by DEFAULT_SEED
    seed_load = 1'b1; seed_in = '1;
    tick();
    seed_load = 1'b0;
    check("seed_ones", dut.r_state, 64'h1);
    free_run = 1'b1;
    tick();
    free_run = 1'b0;
    check("free_step", dut.r_state, 64'h3);
    tick();
    check("idle_hold", dut.r_state, 64'h3);

    // Round-robin order with all four requesting
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    m_state = 64'h1;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      m_state = lfsr_steps(m_state, SHIFTS);
      exp_g   = 4'b0001 << (k % 4);
      check("rr_lat",  n,            17);
      check("rr_gnt",  bus.gnt,      exp_g);
      check("rr_rand", bus.rand_out, m_state[15:0]);
      bus.req = bus.req & ~exp_g;
      tick();
      check("rr_gap_busy", busy,    1'b0);
      check("rr_gap_gnt",  bus.gnt, '0);
      if (k == 3) bus.req = 4'b0001;
    end

    // seed_load during SHIFT cancels owner 2; other req changes are ignored
    bus.req = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    bus.req = 4'b1100;
    tick();
    check("mid_shift_busy", busy, 1'b1);
    seed_v    = 64'h1234_5678_9ABC_DEF0;
    seed_load = 1'b1; seed_in = seed_v;
    tick();
    seed_load = 1'b0;
    check("cancel_busy",  busy,         1'b0);
    check("cancel_gnt",   bus.gnt,      '0);
    check("cancel_state", dut.r_state,  seed_v);
    check("cancel_rr",    dut.r_rr_ptr, 1);
    wait_gnt(n);
    m_state = lfsr_steps(seed_v, SHIFTS);
    check("rearb_lat",  n,            17);
    check("rearb_gnt",  bus.gnt,      4'b0100);
    check("rearb_rand", bus.rand_out, m_state[15:0]);
    bus.req = 4'b1000;
    tick();
    check("rearb_rr", dut.r_rr_ptr, 3);

    // Owner 3 drops req during SHIFT: the word is discarded
    for (int i = 0; i < 5; i++) tick();
    bus.req = '0;
    for (int i = 0; i < 12; i++) tick();
    check("drop_busy", busy,         1'b1);
    check("drop_gnt",  bus.gnt,      '0);
    check("drop_rand", bus.rand_out, '0);
    tick();
    check("drop_rr",   dut.r_rr_ptr, 0);
    check("drop_idle", busy,         1'b0);

    // Reset during GRANT
    bus.req = 4'b0001;
    wait_gnt(n);
    check("pre_rst_gnt", bus.gnt, 4'b0001);
    reset = 1'b1;
    tick();
    check("grst_gnt",   bus.gnt,     '0);
    check("grst_busy",  busy,        1'b0);
    check("grst_state", dut.r_state, 64'h1);
    reset   = 1'b0;
    bus.req = '0;

    // Free-run with no requests: one step per cycle
    free_run = 1'b1;
    tick();
    check("fr_state1", dut.r_state, 64'h3);
    check("fr_gnt1",   bus.gnt,     '0);
    tick();
    check("fr_state2", dut.r_state, 64'h7);
    tick();
    check("fr_state3", dut.r_state, 64'hF);
    check("fr_gnt3",   bus.gnt,     '0);
    free_run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
